// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: round-robin coefficient loader and per-sample MAC frame
// sequencer for the symmetric-FIR datapath (bank RAMs, multipliers,
// accumulators and final cross-lane adder).
module fir_mac_sequencer #(
  parameter int unsigned P_NUM_BANK      = 2,
  parameter int unsigned P_TAPS_PER_BANK = 10,
  parameter int unsigned P_ADDR_W        = 4,
  parameter int unsigned P_COEFF_W       = 16
) (
  input  logic                            iClk_12M,
  input  logic                            iRst,
  input  logic                            iEnSample_600k,
  input  logic                            iCoeffUpdate,
  input  logic                            iCoeffValid,
  input  logic [P_COEFF_W-1:0]            iCoeffData,
  output logic [P_NUM_BANK-1:0]           oCsnRam,
  output logic [P_NUM_BANK-1:0]           oWrnRam,
  output logic [P_NUM_BANK*P_ADDR_W-1:0]  oAddrRam,
  output logic [P_NUM_BANK*P_COEFF_W-1:0] oWrDtRam,
  output logic                            oEnDelay,
  output logic                            oEnMul,
  output logic                            oEnAcc,
  output logic                            oAccClr,
  output logic                            oEnAdd,
  output logic                            oSumValid,
  output logic                            oLoadDone,
  output logic                            oLoadErr,
  output logic                            oOverrun,
  output logic [P_ADDR_W:0]               oTapCnt
);

  localparam int unsigned LP_BC_W  = (P_NUM_BANK > 1) ? $clog2(P_NUM_BANK) : 1;
  localparam int unsigned LP_CNT_W = P_ADDR_W + 1;
  localparam int unsigned LP_AW_T  = P_NUM_BANK * P_ADDR_W;
  localparam int unsigned LP_DW_T  = P_NUM_BANK * P_COEFF_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PAD,
    S_RUN,
    S_MAC,
    S_DRAIN,
    S_SUM
  } state_t;

  // Current registered state, counters and outputs
  state_t                r_state;
  logic [LP_BC_W-1:0]    r_bc;
  logic [LP_CNT_W-1:0]   r_ac;
  logic [P_NUM_BANK-1:0] r_csn;
  logic [P_NUM_BANK-1:0] r_wrn;
  logic [LP_AW_T-1:0]    r_addr;
  logic [LP_DW_T-1:0]    r_wrdt;
  logic                  r_en_delay;
  logic                  r_en_mac;
  logic                  r_acc_clr;
  logic                  r_en_add;
  logic                  r_sum_valid;
  logic                  r_load_done;
  logic                  r_load_err;
  logic                  r_overrun;
  logic [LP_CNT_W-1:0]   r_tap_cnt;

  // Next-cycle values
  state_t                w_state;
  logic [LP_BC_W-1:0]    w_bc;
  logic [LP_CNT_W-1:0]   w_ac;
  logic [LP_CNT_W-1:0]   w_ac_inc;
  logic [P_NUM_BANK-1:0] w_csn;
  logic [P_NUM_BANK-1:0] w_wrn;
  logic [LP_AW_T-1:0]    w_addr;
  logic [LP_DW_T-1:0]    w_wrdt;
  logic                  w_en_delay;
  logic                  w_en_mac;
  logic                  w_acc_clr;
  logic                  w_en_add;
  logic                  w_sum_valid;
  logic                  w_load_done;
  logic                  w_load_err;
  logic                  w_overrun;
  logic [LP_CNT_W-1:0]   w_tap_cnt;
  logic                  w_enter_load;

  // State register and registered outputs, synchronous reset to IDLE
  always_ff @(posedge iClk_12M) begin
    if (iRst) begin
      r_state     <= S_IDLE;
      r_bc        <= '0;
      r_ac        <= '0;
      r_csn       <= '1;
      r_wrn       <= '1;
      r_addr      <= '0;
      r_wrdt      <= '0;
      r_en_delay  <= 1'b0;
      r_en_mac    <= 1'b0;
      r_acc_clr   <= 1'b0;
      r_en_add    <= 1'b0;
      r_sum_valid <= 1'b0;
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
      r_overrun   <= 1'b0;
      r_tap_cnt   <= '0;
    end else begin
      r_state     <= w_state;
      r_bc        <= w_bc;
      r_ac        <= w_ac;
      r_csn       <= w_csn;
      r_wrn       <= w_wrn;
      r_addr      <= w_addr;
      r_wrdt      <= w_wrdt;
      r_en_delay  <= w_en_delay;
      r_en_mac    <= w_en_mac;
      r_acc_clr   <= w_acc_clr;
      r_en_add    <= w_en_add;
      r_sum_valid <= w_sum_valid;
      r_load_done <= w_load_done;
      r_load_err  <= w_load_err;
      r_overrun   <= w_overrun;
      r_tap_cnt   <= w_tap_cnt;
    end
  end

  // Next-state and next-output logic; outputs are one cycle behind the decision
  always_comb begin
    w_state      = r_state;
    w_bc         = r_bc;
    w_ac         = r_ac;
    w_ac_inc     = r_ac + LP_CNT_W'(1);
    w_csn        = '1;
    w_wrn        = '1;
    w_addr       = r_addr;
    w_wrdt       = r_wrdt;
    w_en_delay   = 1'b0;
    // Multiply/accumulate trails each MAC address cycle by the RAM read latency
    w_en_mac     = (r_state == S_MAC);
    w_acc_clr    = (r_state == S_MAC) && (r_ac == '0);
    w_en_add     = 1'b0;
    w_sum_valid  = (r_state == S_SUM);
    w_load_done  = r_load_done;
    w_load_err   = r_load_err;
    w_overrun    = r_overrun;
    w_tap_cnt    = r_tap_cnt;
    w_enter_load = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (iCoeffUpdate) begin
          w_enter_load = 1'b1;
        end
      end

      S_LOAD: begin
        if (!iCoeffUpdate) begin
          if (r_bc != '0) begin
            // Zero-fill the unused tail of the last address row in one cycle
            w_state = S_PAD;
            for (int unsigned b = 0; b < P_NUM_BANK; b++) begin
              if (LP_BC_W'(b) >= r_bc) begin
                w_csn[b] = 1'b0;
                w_wrn[b] = 1'b0;
                w_addr[b*P_ADDR_W +: P_ADDR_W]   = r_ac[P_ADDR_W-1:0];
                w_wrdt[b*P_COEFF_W +: P_COEFF_W] = '0;
              end
            end
          end else if (r_ac == '0) begin
            w_state   = S_IDLE;
            w_tap_cnt = '0;
          end else begin
            w_state     = S_RUN;
            w_tap_cnt   = r_ac;
            w_load_done = 1'b1;
          end
        end else if (iCoeffValid) begin
          if (r_ac == LP_CNT_W'(P_TAPS_PER_BANK)) begin
            w_load_err = 1'b1;
          end else begin
            for (int unsigned b = 0; b < P_NUM_BANK; b++) begin
              if (LP_BC_W'(b) == r_bc) begin
                w_csn[b] = 1'b0;
                w_wrn[b] = 1'b0;
                w_addr[b*P_ADDR_W +: P_ADDR_W]   = r_ac[P_ADDR_W-1:0];
                w_wrdt[b*P_COEFF_W +: P_COEFF_W] = iCoeffData;
              end
            end
            // Round-robin bank pointer; the address advances once per full row
            if (r_bc == LP_BC_W'(P_NUM_BANK - 1)) begin
              w_bc = '0;
              w_ac = w_ac_inc;
            end else begin
              w_bc = r_bc + LP_BC_W'(1);
            end
          end
        end
      end

      S_PAD: begin
        w_state     = S_RUN;
        w_tap_cnt   = w_ac_inc;
        w_load_done = 1'b1;
      end

      S_RUN: begin
        if (iCoeffUpdate) begin
          w_enter_load = 1'b1;
        end else if (iEnSample_600k) begin
          w_state    = S_MAC;
          w_ac       = '0;
          w_en_delay = 1'b1;
          w_csn      = '0;
          for (int unsigned b = 0; b < P_NUM_BANK; b++) begin
            w_addr[b*P_ADDR_W +: P_ADDR_W] = '0;
          end
        end
      end

      S_MAC: begin
        w_overrun = r_overrun | iEnSample_600k;
        if (w_ac_inc == r_tap_cnt) begin
          w_state = S_DRAIN;
        end else begin
          w_ac  = w_ac_inc;
          w_csn = '0;
          for (int unsigned b = 0; b < P_NUM_BANK; b++) begin
            w_addr[b*P_ADDR_W +: P_ADDR_W] = w_ac_inc[P_ADDR_W-1:0];
          end
        end
      end

      S_DRAIN: begin
        w_overrun = r_overrun | iEnSample_600k;
        w_state   = S_SUM;
        w_en_add  = 1'b1;
      end

      S_SUM: begin
        w_overrun = r_overrun | iEnSample_600k;
        w_state   = S_RUN;
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase

    // Opening a load session restarts the counters and clears status
    if (w_enter_load) begin
      w_state     = S_LOAD;
      w_bc        = '0;
      w_ac        = '0;
      w_load_done = 1'b0;
      w_load_err  = 1'b0;
      w_overrun   = 1'b0;
    end
  end

  assign oCsnRam   = r_csn;
  assign oWrnRam   = r_wrn;
  assign oAddrRam  = r_addr;
  assign oWrDtRam  = r_wrdt;
  assign oEnDelay  = r_en_delay;
  assign oEnMul    = r_en_mac;
  assign oEnAcc    = r_en_mac;
  assign oAccClr   = r_acc_clr;
  assign oEnAdd    = r_en_add;
  assign oSumValid = r_sum_valid;
  assign oLoadDone = r_load_done;
  assign oLoadErr  = r_load_err;
  assign oOverrun  = r_overrun;
  assign oTapCnt   = r_tap_cnt;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Testbench for fir_mac_sequencer: directed load/frame/overrun/reset steps with
// random coefficient data, checked against a coefficient-placement model.
module tb_fir_mac_sequencer;

  localparam int unsigned NB  = 2;
  localparam int unsigned TPB = 10;
  localparam int unsigned AW  = 4;
  localparam int unsigned CW  = 16;
  localparam int unsigned DEPTH = 1 << AW;

  logic              clk = 1'b0;
  logic              rst;
  logic              strobe;
  logic              upd;
  logic              cvalid;
  logic [CW-1:0]     cdata;
  logic [NB-1:0]     csn;
  logic [NB-1:0]     wrn;
  logic [NB*AW-1:0]  addr;
  logic [NB*CW-1:0]  wrdt;
  logic              en_delay, en_mul, en_acc, acc_clr, en_add, sum_valid;
  logic              load_done, load_err, overrun;
  logic [AW:0]       tap_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  // Model state: coefficients sent, and RAM contents as seen on the bank bus
  logic [CW-1:0] coef[$];
  logic [CW-1:0] shadow[NB][DEPTH];
  bit            written[NB][DEPTH];
  int            nwr;
  int            cur_t;

  always #5 clk = ~clk;

  fir_mac_sequencer #(
    .P_NUM_BANK(NB), .P_TAPS_PER_BANK(TPB), .P_ADDR_W(AW), .P_COEFF_W(CW)
  ) dut (
    .iClk_12M(clk), .iRst(rst), .iEnSample_600k(strobe),
    .iCoeffUpdate(upd), .iCoeffValid(cvalid), .iCoeffData(cdata),
    .oCsnRam(csn), .oWrnRam(wrn), .oAddrRam(addr), .oWrDtRam(wrdt),
    .oEnDelay(en_delay), .oEnMul(en_mul), .oEnAcc(en_acc), .oAccClr(acc_clr),
    .oEnAdd(en_add), .oSumValid(sum_valid), .oLoadDone(load_done),
    .oLoadErr(load_err), .oOverrun(overrun), .oTapCnt(tap_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Record any bank write visible on the RAM bus this cycle
  task automatic capture();
    for (int b = 0; b < NB; b++) begin
      if (!csn[b] && !wrn[b]) begin
        shadow[b][addr[b*AW +: AW]]  = wrdt[b*CW +: CW];
        written[b][addr[b*AW +: AW]] = 1'b1;
        nwr++;
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_csn"}, 64'(csn), 64'({NB{1'b1}}));
    chk({tag, "_wrn"}, 64'(wrn), 64'({NB{1'b1}}));
    chk({tag, "_addr"}, 64'(addr), 64'(0));
    chk({tag, "_wrdt"}, 64'(wrdt), 64'(0));
    chk({tag, "_flags"},
        64'({en_delay, en_mul, en_acc, acc_clr, en_add, sum_valid, load_done, load_err, overrun}),
        64'(0));
    chk({tag, "_tapcnt"}, 64'(tap_cnt), 64'(0));
  endtask

  // Load n coefficients; expected placement: coefficient i -> bank i%NB, addr i/NB
  task automatic do_load(input int n, input bit seq_vals);
    int n_eff, t, rem, idx;
    logic [NB-1:0] pad_csn;
    logic [CW-1:0] expv;
    n_eff = (n > int'(NB*TPB)) ? int'(NB*TPB) : n;
    t     = (n_eff + int'(NB) - 1) / int'(NB);
    rem   = n_eff % int'(NB);
    coef.delete();
    for (int i = 0; i < n; i++) coef.push_back(seq_vals ? CW'(i + 1) : CW'($urandom));
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < DEPTH; a++) begin
        shadow[b][a]  = '0;
        written[b][a] = 1'b0;
      end
    nwr = 0;

    upd = 1'b1;
    step(); capture();
    chk("load_entry_status", 64'({load_done, load_err, overrun}), 64'(0));
    for (int i = 0; i < n; i++) begin
      cvalid = 1'b1;
      cdata  = coef[i];
      step(); capture();
    end
    cvalid = 1'b0;
    upd    = 1'b0;
    step(); capture();
    if (rem != 0) begin
      for (int b = 0; b < NB; b++) pad_csn[b] = (b < rem);
      chk("pad_csn", 64'(csn), 64'(pad_csn));
      chk("pad_done_early", 64'(load_done), 64'(0));
      step(); capture();
    end
    chk("tap_cnt", 64'(tap_cnt), 64'(t));
    chk("load_done", 64'(load_done), 64'(t != 0));
    chk("load_err", 64'(load_err), 64'(n > int'(NB*TPB)));
    chk("write_count", 64'(nwr), 64'(n_eff + ((rem != 0) ? int'(NB) - rem : 0)));
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < t; a++) begin
        idx  = a * int'(NB) + b;
        expv = (idx < n_eff) ? coef[idx] : '0;
        chk("bank_content", 64'({written[b][a], shadow[b][a]}), 64'({1'b1, expv}));
      end
    cur_t = t;
  endtask

  // One sample frame from RUN; optionally drop a strobe at s+5
  task automatic do_frame(input int t, input bit probe);
    logic [5:0] exp_ctl;
    strobe = 1'b1;
    step();
    strobe = 1'b0;
    for (int j = 1; j <= t + 3; j++) begin
      exp_ctl = {j == 1, (j >= 2) && (j <= t + 1), (j >= 2) && (j <= t + 1),
                 j == 2, j == t + 2, j == t + 3};
      chk("frame_ctl", 64'({en_delay, en_mul, en_acc, acc_clr, en_add, sum_valid}), 64'(exp_ctl));
      chk("frame_csn_wrn", 64'({csn, wrn}), 64'({(j <= t) ? {NB{1'b0}} : {NB{1'b1}}, {NB{1'b1}}}));
      if (j <= t)
        for (int b = 0; b < NB; b++)
          chk("frame_addr", 64'(addr[b*AW +: AW]), 64'(j - 1));
      if (j < t + 3) begin
        strobe = probe && (j == 5);
        step();
        strobe = 1'b0;
      end
    end
    if (probe) chk("overrun_set", 64'(overrun), 64'(1));
  endtask

  initial begin
    rst = 1'b1; strobe = 1'b0; upd = 1'b0; cvalid = 1'b0; cdata = '0; cur_t = 0;
    step(); step();
    rst = 1'b0;
    step();
    check_reset_values("init");

    // Strobe while idle is ignored
    strobe = 1'b1; step(); strobe = 1'b0;
    chk("idle_strobe", 64'({en_delay, overrun, csn}), 64'({2'b00, {NB{1'b1}}}));

    // Full load 1..20, then frame with a dropped strobe, then back-to-back frame
    do_load(20, 1'b1);
    do_frame(cur_t, 1'b1);
    do_frame(cur_t, 1'b0);
    chk("overrun_sticky", 64'(overrun), 64'(1));

    // Partial load with padding; reload clears the overrun flag
    do_load(5, 1'b0);
    chk("overrun_cleared", 64'(overrun), 64'(0));
    do_frame(cur_t, 1'b0);

    // Overflow: the 21st coefficient is ignored
    do_load(21, 1'b0);
    do_frame(cur_t, 1'b0);

    // Random load sizes, each followed by a frame
    for (int r = 0; r < 4; r++) begin
      do_load(int'($urandom_range(1, 23)), 1'b0);
      do_frame(cur_t, 1'b0);
    end

    // Empty load returns to idle; strobes stay ignored
    do_load(0, 1'b0);
    strobe = 1'b1; step(); strobe = 1'b0;
    chk("empty_load_strobe", 64'({en_delay, load_done}), 64'(0));

    // Reset in the middle of a frame
    do_load(20, 1'b0);
    strobe = 1'b1; step(); strobe = 1'b0;
    step(); step(); step();
    rst = 1'b1; step(); step();
    rst = 1'b0; step();
    check_reset_values("midframe_rst");
    strobe = 1'b1; step(); strobe = 1'b0;
    chk("post_rst_strobe", 64'({en_delay, csn}), 64'({1'b0, {NB{1'b1}}}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/fir_mac_sequencer.md
# fir_mac_sequencer

Parametrised control sequencer for the symmetric-FIR datapath. It replaces fixed odd/even coefficient steering with round-robin loading across `P_NUM_BANK` coefficient RAM banks. It derives the active tap count from the number of coefficients loaded and zero-pads the last address row. It runs a per-sample read/multiply/accumulate/sum frame and flags dropped samples and coefficient overflow. It sits between the coefficient/sample interface and the bank RAMs, multipliers, accumulators and final adder.

## Interface
- `P_NUM_BANK`, default 2: number of coefficient RAM banks and MAC lanes (≥1).
- `P_TAPS_PER_BANK`, default 10: maximum addresses used per bank (≤2^`P_ADDR_W`).
- `P_ADDR_W`, default 4: bank RAM address width.
- `P_COEFF_W`, default 16: coefficient width, signed.
- `iClk_12M`, in, 1: the single clock.
- `iRst`, in, 1: reset, synchronous, active-high.
- `iEnSample_600k`, in, 1: new-sample strobe, one cycle.
- `iCoeffUpdate`, in, 1: level request that opens and holds a coefficient-load session.
- `iCoeffValid`, in, 1: one coefficient write per cycle high, while loading.
- `iCoeffData`, in, `P_COEFF_W`: coefficient value.
- `oCsnRam`, out, `P_NUM_BANK`: per-bank chip select, active-low.
- `oWrnRam`, out, `P_NUM_BANK`: per-bank write enable, active-low.
- `oAddrRam`, out, `P_NUM_BANK*P_ADDR_W`: per-bank address; bank b at bits [b*AW +: AW].
- `oWrDtRam`, out, `P_NUM_BANK*P_COEFF_W`: per-bank write data.
- `oEnDelay`, out, 1: one-cycle shift pulse to the sample delay line.
- `oEnMul`, `oEnAcc`, out, 1: multiplier and accumulator enable.
- `oAccClr`, out, 1: accumulator loads the product instead of adding it.
- `oEnAdd`, out, 1: cross-lane final adder enable.
- `oSumValid`, out, 1: one-cycle pulse marking a valid filter output.
- `oLoadDone`, out, 1: coefficients valid, filter running.
- `oLoadErr`, out, 1: sticky flag, too many coefficients written.
- `oOverrun`, out, 1: sticky flag, sample strobe dropped.
- `oTapCnt`, out, `P_ADDR_W+1`: active addresses per bank (T).

## Operation
- All outputs are registered. On reset they take these values:
  - `oCsnRam` and `oWrnRam` all 1.
  - `oAddrRam` and `oWrDtRam` 0.
  - All enables, `oSumValid`, `oLoadDone`, `oLoadErr` and `oOverrun` 0.
  - `oTapCnt` 0, state IDLE.
- States are IDLE, LOAD, PAD, RUN, MAC, DRAIN and SUM.
- IDLE/RUN → LOAD when `iCoeffUpdate`=1. If the request arrives during MAC/DRAIN/SUM, the frame completes first and LOAD follows the return to RUN.
- Entering LOAD clears the bank counter bc, the address counter ac, `oLoadDone`, `oLoadErr` and `oOverrun`.
- Each `iCoeffValid` in LOAD writes `iCoeffData` to bank bc at address ac. The next cycle shows that bank with csn=0, wrn=0, its address and data; all other banks have csn=1.
  - bc increments and wraps at `P_NUM_BANK`; ac increments on the wrap.
  - Coefficient i therefore lands in bank i mod NB at address i div NB. No divider is used.
- A write when ac=`P_TAPS_PER_BANK` is ignored and sets `oLoadErr`.
- LOAD exits when `iCoeffUpdate` is sampled 0. T = ac + (bc≠0).
  - If bc≠0, go to PAD: one cycle writing 0 to banks bc..NB-1 at address ac simultaneously, then RUN.
  - If T=0, go to IDLE with `oLoadDone`=0.
  - Otherwise go to RUN. `oTapCnt`=T and `oLoadDone`=1 from the first RUN cycle.
- Strobes in IDLE/LOAD/PAD are ignored and do not raise `oOverrun`.
- In RUN, a strobe starts a frame (see Timing). All banks read the same address k=0..T-1 with csn=0, wrn=1.
- A strobe during MAC/DRAIN/SUM is dropped and sets `oOverrun`. A strobe in the cycle the sequencer is back in RUN is accepted.
- `iRst` in any state returns to IDLE at the next edge with reset values. Coefficients must then be reloaded.

## Timing
- A strobe sampled in RUN at cycle s produces the frame below. Strobe-to-`oSumValid` latency is T+3 and the minimum strobe period is T+3.
  - s+1: `oEnDelay`=1 for one cycle.
  - s+1..s+T: MAC; `oAddrRam`=k=0..T-1.
  - s+2..s+T+1: `oEnMul`=`oEnAcc`=1, matching the 1-cycle RAM read latency.
  - s+2 only: `oAccClr`=1.
  - s+T+1: DRAIN.
  - s+T+2: SUM with `oEnAdd`=1.
  - s+T+3: RUN with `oSumValid`=1.
- Load write latency: the RAM write appears 1 cycle after `iCoeffValid`.
- Load exit latency, counted from the cycle `iCoeffUpdate` is sampled 0:
  - Without padding, `oLoadDone` rises 1 cycle later.
  - With padding, the PAD write appears 1 cycle later and `oLoadDone` rises 2 cycles later.

## Test plan
- Reset check: assert `iRst` for 2 cycles mid-frame. Next cycle, every output holds its reset value and the state is IDLE.
- Full load (NB=2, T=10): write 1..20.
  - Bank0 addresses 0..9 hold 1,3,…,19; bank1 holds 2,…,20.
  - `oTapCnt`=10, no PAD write, `oLoadErr`=0.
- Partial load: write 5 coefficients.
  - One cycle after update falls, bank1 writes 0 at address 2 and bank0 stays idle (csn=1).
  - `oTapCnt`=3 and `oLoadDone`=1 the cycle after that.
- Frame: T=10, strobe at s.
  - `oEnDelay`@s+1, `oAddrRam` 0..9 over s+1..s+10.
  - `oEnAcc`@s+2..s+11, `oAccClr`@s+2 only, `oEnAdd`@s+12, `oSumValid`@s+13.
- Overrun: a strobe at s+5 is dropped and `oOverrun`=1. A strobe at s+13 starts a new frame. Re-entering LOAD clears `oOverrun`.
- Overflow: write 21 coefficients with T_max=10. `oLoadErr`=1, there is no 21st RAM write, and `oTapCnt`=10.
